// File: rtl/lf_sub_pkg.sv
// Shared types and sizing for the pipelined Ladner-Fischer subtractor.
package lf_sub_pkg;
    localparam int WIDTH  = 9;
    localparam int LEVELS = 4;
    localparam int TAG_W  = 4;
    localparam int SPLIT  = 2;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_vec_t;

    typedef logic [WIDTH:0] diff_t;

    typedef struct packed {
        gp_vec_t          gp;
        logic [WIDTH-1:0] p0;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        diff_t            diff;
        logic [TAG_W-1:0] tag;
        logic             uflow;
    } s2_t;
endpackage

// File: rtl/lf_carry_op.sv
// Prefix black cell: merges a higher (gi1/pi1) group with the adjacent lower (gi2/pi2) group.
module lf_carry_op (
    input  logic gi1_i,
    input  logic pi1_i,
    input  logic gi2_i,
    input  logic pi2_i,
    output logic go_o,
    output logic po_o
);
    assign go_o = gi1_i | (gi2_i & pi1_i);
    assign po_o = pi1_i & pi2_i;
endmodule

// File: rtl/lf_pipe_subtractor.sv
// Two-stage X - Y (as X + ~Y + 1) with valid/ready on both sides.
// Define LF_SUB_SATURATE_EN to clamp negative differences to zero.
module lf_pipe_subtractor
    import lf_sub_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_x_i,
    input  logic [WIDTH-1:0] in_y_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output diff_t            out_diff_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_uflow_o
);
    logic [2:1] vld_pipe_q;
    logic       adv1, adv2;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    gp_vec_t    gp0, gp_s0, gp_s2;

    assign adv2       = ~vld_pipe_q[2] | out_ready_i;
    assign adv1       = ~vld_pipe_q[1] | adv2;
    assign in_ready_o = adv1;

    assign gp0.g = in_x_i & ~in_y_i;
    assign gp0.p = in_x_i ^ ~in_y_i;

    // Level l merges every bit with bit (l-1) set into the prefix ending just below its block.
    // Levels 1..SPLIT run ahead of the stage 1 register, the rest after it.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int K = 1 << (l - 1);
        gp_vec_t src, res;
        if (l == 1) begin : g_src_in
            assign src = gp0;
        end else if (l == SPLIT + 1) begin : g_src_reg
            assign src = s1_q.gp;
        end else begin : g_src_prev
            assign src = g_lvl[l-1].res;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i / K) % 2) == 1) begin : g_node
                lf_carry_op u_op (
                    .gi1_i (src.g[i]),
                    .pi1_i (src.p[i]),
                    .gi2_i (src.g[(i / K) * K - 1]),
                    .pi2_i (src.p[(i / K) * K - 1]),
                    .go_o  (res.g[i]),
                    .po_o  (res.p[i])
                );
            end else begin : g_pass
                assign res.g[i] = src.g[i];
                assign res.p[i] = src.p[i];
            end
        end
    end

    assign gp_s0 = g_lvl[SPLIT].res;
    assign gp_s2 = g_lvl[LEVELS].res;

    always_comb begin
        s1_d.gp  = gp_s0;
        s1_d.p0  = gp0.p;
        s1_d.tag = in_tag_i;
    end

    // Carry-in is a constant 1, so a group propagate alone produces a carry.
    logic [WIDTH-1:0] carry;
    logic             borrow;
    assign carry  = {gp_s2.g[WIDTH-2:0] | gp_s2.p[WIDTH-2:0], 1'b1};
    assign borrow = ~(gp_s2.g[WIDTH-1] | gp_s2.p[WIDTH-1]);

    always_comb begin
        s2_d.tag   = s1_q.tag;
        s2_d.uflow = borrow;
        s2_d.diff  = {borrow, s1_q.p0 ^ carry};
`ifdef LF_SUB_SATURATE_EN
        if (borrow) s2_d.diff = '0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
        end else begin
            if (adv1) vld_pipe_q[1] <= in_valid_i;
            if (adv2) vld_pipe_q[2] <= vld_pipe_q[1];
        end
    end

    // Data registers carry no reset; the outputs are masked by out_valid instead.
    always_ff @(posedge clk_i) begin
        if (adv1) s1_q <= s1_d;
        if (adv2) s2_q <= s2_d;
    end

    assign out_valid_o = vld_pipe_q[2];
    assign out_diff_o  = vld_pipe_q[2] ? s2_q.diff  : '0;
    assign out_tag_o   = vld_pipe_q[2] ? s2_q.tag   : '0;
    assign out_uflow_o = vld_pipe_q[2] ? s2_q.uflow : 1'b0;
endmodule
